// File: rtl/ex_pkg.sv
// -----------------------------------------------------------------------------
// ex_pkg: shared constants for the execute stage.
//   - OP_*      : 4-bit ARM data-processing opcodes
//   - COND_*    : 4-bit ARM condition field encodings
//   - FLAG_*    : bit positions of N, Z, C, V inside the NZCV register
//   - cond_pass : evaluates a condition field against an NZCV value
// -----------------------------------------------------------------------------
package ex_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;   // COND_NV
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if: bundle between the ID/EX register, the forwarding sources and
// the EX/MEM outputs of ex_stage.
//   master : pipeline side (drives ID/EX controls/operands and forwarding data,
//            receives branch resolution, flags and EX/MEM outputs)
//   slave  : ex_stage itself
// Parameters: DW datapath width, AW register address width.
// -----------------------------------------------------------------------------
interface ex_stage_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          EXMEMWrite;
    logic [3:0]    ALUOpE;
    logic          ALUSrcE, SvalueE, BranchE, RegWriteE, MemWriteE, MemtoRegE, CmpE;
    logic [3:0]    CondE;
    logic [DW-1:0] ExtImmE, RD1E, RD2E, PCPlus8E;
    logic [AW-1:0] ReadAddr1E, ReadAddr2E, WriteAddrE;
    logic [DW-1:0] ALUResultM_fb, ResultW;
    logic [AW-1:0] WriteAddrM_fb, WriteAddrW;
    logic          RegWriteM_fb, RegWriteW;

    logic          BranchTakenE;
    logic [DW-1:0] BranchTargetE;
    logic [3:0]    NZCV;
    logic [DW-1:0] ALUResultM, WriteDataM;
    logic [AW-1:0] WriteAddrM;
    logic          RegWriteM, MemWriteM, MemtoRegM;

    modport master (
        output EXMEMWrite, ALUOpE, ALUSrcE, SvalueE, BranchE, RegWriteE, MemWriteE,
               MemtoRegE, CmpE, CondE, ExtImmE, RD1E, RD2E, PCPlus8E,
               ReadAddr1E, ReadAddr2E, WriteAddrE, ALUResultM_fb, ResultW,
               WriteAddrM_fb, WriteAddrW, RegWriteM_fb, RegWriteW,
        input  BranchTakenE, BranchTargetE, NZCV, ALUResultM, WriteDataM,
               WriteAddrM, RegWriteM, MemWriteM, MemtoRegM
    );

    modport slave (
        input  EXMEMWrite, ALUOpE, ALUSrcE, SvalueE, BranchE, RegWriteE, MemWriteE,
               MemtoRegE, CmpE, CondE, ExtImmE, RD1E, RD2E, PCPlus8E,
               ReadAddr1E, ReadAddr2E, WriteAddrE, ALUResultM_fb, ResultW,
               WriteAddrM_fb, WriteAddrW, RegWriteM_fb, RegWriteW,
        output BranchTakenE, BranchTargetE, NZCV, ALUResultM, WriteDataM,
               WriteAddrM, RegWriteM, MemWriteM, MemtoRegM
    );
endinterface

// File: rtl/ex_alu.sv
// -----------------------------------------------------------------------------
// ex_alu: combinational 16-op ARM data-processing ALU.
//   op_i           : opcode (ex_pkg OP_*)
//   a_i, b_i       : operands
//   cin_i          : current carry flag (used by ADC/SBC/RSC)
//   result_o       : ALU result
//   n_o,z_o,c_o,v_o: flags derived from this operation
//   writes_flags_o : 1 when the op is arithmetic, i.e. c_o/v_o are meaningful;
//                    logical ops leave C and V to the caller's current flags
//   is_cmp_o       : TST/TEQ/CMP/CMN (flag-only ops, never write a register)
// -----------------------------------------------------------------------------
module ex_alu
    import ex_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          cin_i,
    output logic [DW-1:0] result_o,
    output logic          n_o,
    output logic          z_o,
    output logic          c_o,
    output logic          v_o,
    output logic          writes_flags_o,
    output logic          is_cmp_o
);

    logic [DW-1:0] x, y;
    logic          ci;
    logic          arith;
    logic [DW:0]   sum;

    // All arithmetic maps onto x + y + ci; subtraction is x + ~y + 1 so the
    // carry-out is the ARM "not borrow".
    always_comb begin
        x     = a_i;
        y     = b_i;
        ci    = 1'b0;
        arith = 1'b1;
        case (op_i)
            OP_SUB, OP_CMP: begin y = ~b_i; ci = 1'b1;  end
            OP_RSB:         begin x = b_i; y = ~a_i; ci = 1'b1; end
            OP_ADD, OP_CMN: begin ci = 1'b0; end
            OP_ADC:         begin ci = cin_i; end
            OP_SBC:         begin y = ~b_i; ci = cin_i; end
            OP_RSC:         begin x = b_i; y = ~a_i; ci = cin_i; end
            default:        arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};

    always_comb begin
        case (op_i)
            OP_AND, OP_TST: result_o = a_i & b_i;
            OP_EOR, OP_TEQ: result_o = a_i ^ b_i;
            OP_ORR:         result_o = a_i | b_i;
            OP_MOV:         result_o = b_i;
            OP_BIC:         result_o = a_i & ~b_i;
            OP_MVN:         result_o = ~b_i;
            default:        result_o = sum[DW-1:0];
        endcase
    end

    assign n_o            = result_o[DW-1];
    assign z_o            = (result_o == '0);
    assign c_o            = sum[DW];
    // Overflow: both adder inputs share a sign that the sum does not.
    assign v_o            = (x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1]);
    assign writes_flags_o = arith;
    assign is_cmp_o       = (op_i[3:2] == 2'b10);

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage: ARM execute stage.
//   clk   : clock; all state updates on the falling edge
//   reset : asynchronous active-low reset
//   bus   : ex_stage_if.slave -- ID/EX controls and operands, MEM/WB
//           forwarding sources, branch resolution, NZCV and EX/MEM outputs
// Holds the NZCV register and the EX/MEM pipeline register. Conditional
// execution is checked against the flags of the previous instruction; a
// failed condition or EXMEMWrite==0 turns the instruction into a bubble.
// Build option: define EX_FORWARD_EN to enable MEM/WB operand forwarding;
// otherwise operands come straight from RD1E/RD2E and the forwarding inputs
// are ignored.
// -----------------------------------------------------------------------------
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input logic      clk,
    input logic      reset,
    ex_stage_if.slave bus
);

    logic [DW-1:0] src_a, src_b, op_b;
    logic [DW-1:0] alu_res;
    logic          alu_n, alu_z, alu_c, alu_v, alu_wf, alu_cmp;
    logic          cond_ok, flag_we, latch_en;
    logic [3:0]    nzcv_q, nzcv_d;

    logic [DW-1:0] alu_result_q, write_data_q;
    logic [AW-1:0] write_addr_q;
    logic          reg_write_q, mem_write_q, mem_to_reg_q;

`ifdef EX_FORWARD_EN
    // MEM has priority over WB; r15 reads as PC-relative data, never forwarded.
    always_comb begin
        src_a = bus.RD1E;
        if (bus.ReadAddr1E != {AW{1'b1}}) begin
            if (bus.RegWriteM_fb && (bus.WriteAddrM_fb == bus.ReadAddr1E))
                src_a = bus.ALUResultM_fb;
            else if (bus.RegWriteW && (bus.WriteAddrW == bus.ReadAddr1E))
                src_a = bus.ResultW;
        end
    end

    always_comb begin
        src_b = bus.RD2E;
        if (bus.ReadAddr2E != {AW{1'b1}}) begin
            if (bus.RegWriteM_fb && (bus.WriteAddrM_fb == bus.ReadAddr2E))
                src_b = bus.ALUResultM_fb;
            else if (bus.RegWriteW && (bus.WriteAddrW == bus.ReadAddr2E))
                src_b = bus.ResultW;
        end
    end
`else
    assign src_a = bus.RD1E;
    assign src_b = bus.RD2E;

    // Forwarding inputs stay on the interface but are not used in this build.
    logic unused_fwd;
    assign unused_fwd = ^{bus.ALUResultM_fb, bus.ResultW, bus.WriteAddrM_fb,
                          bus.WriteAddrW, bus.RegWriteM_fb, bus.RegWriteW,
                          bus.ReadAddr1E, bus.ReadAddr2E};
`endif

    assign op_b = bus.ALUSrcE ? bus.ExtImmE : src_b;

    ex_alu #(.DW(DW)) u_alu (
        .op_i           (bus.ALUOpE),
        .a_i            (src_a),
        .b_i            (op_b),
        .cin_i          (nzcv_q[FLAG_C]),
        .result_o       (alu_res),
        .n_o            (alu_n),
        .z_o            (alu_z),
        .c_o            (alu_c),
        .v_o            (alu_v),
        .writes_flags_o (alu_wf),
        .is_cmp_o       (alu_cmp)
    );

    assign cond_ok  = cond_pass(bus.CondE, nzcv_q);
    assign latch_en = bus.EXMEMWrite && cond_ok;
    assign flag_we  = (bus.SvalueE || bus.CmpE) && latch_en;

    // Logical ops keep the current C and V.
    assign nzcv_d = {alu_n, alu_z,
                     alu_wf ? alu_c : nzcv_q[FLAG_C],
                     alu_wf ? alu_v : nzcv_q[FLAG_V]};

    assign bus.BranchTakenE  = bus.BranchE && cond_ok;
    assign bus.BranchTargetE = bus.PCPlus8E + (bus.ExtImmE << 2);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            nzcv_q       <= 4'b0000;
            alu_result_q <= '0;
            write_data_q <= '0;
            write_addr_q <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            if (flag_we)
                nzcv_q <= nzcv_d;
            if (latch_en) begin
                alu_result_q <= alu_res;
                write_data_q <= src_b;
                write_addr_q <= bus.WriteAddrE;
                reg_write_q  <= bus.RegWriteE && !alu_cmp;
                mem_write_q  <= bus.MemWriteE;
                mem_to_reg_q <= bus.MemtoRegE;
            end else begin
                alu_result_q <= '0;
                write_data_q <= '0;
                write_addr_q <= '0;
                reg_write_q  <= 1'b0;
                mem_write_q  <= 1'b0;
                mem_to_reg_q <= 1'b0;
            end
        end
    end

    assign bus.NZCV       = nzcv_q;
    assign bus.ALUResultM = alu_result_q;
    assign bus.WriteDataM = write_data_q;
    assign bus.WriteAddrM = write_addr_q;
    assign bus.RegWriteM  = reg_write_q;
    assign bus.MemWriteM  = mem_write_q;
    assign bus.MemtoRegM  = mem_to_reg_q;

endmodule
